// File: rtl/apu_pkg.sv
// Constants and helpers shared by the audio channels (pulse, triangle, noise).
package apu_pkg;

    localparam int                    LFSR_WIDTH   = 15;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED    = 15'h0001;
    localparam int                    TAP_LONG     = 1;
    localparam int                    TAP_SHORT    = 6;
    localparam logic [3:0]            ENV_MAX      = 4'd15;
    localparam int                    SAMPLE_WIDTH = 9;

    typedef struct packed {
        logic       start;
        logic [3:0] divider;
        logic [3:0] decay;
    } env_t;

    // One Galois-free Fibonacci step: feedback enters at the MSB.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] s,
        input logic                  short_mode
    );
        logic fb;
        fb = s[0] ^ (short_mode ? s[TAP_SHORT] : s[TAP_LONG]);
        return {fb, s[LFSR_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/channel_4_noise_lfsr.sv
// 15-bit noise sequence generator; advances one state per i_step.
module noise_lfsr
    import apu_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_step,
    input  logic                  i_mode,
    output logic [LFSR_WIDTH-1:0] o_state
);

    // Seed is non-zero and both tap sets keep the all-zero state unreachable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_state <= LFSR_SEED;
        end else if (i_step) begin
            o_state <= lfsr_next(o_state, i_mode);
        end
    end

endmodule

// File: rtl/channel_4_noise.sv
// Noise voice: prescaled period timer stepping an LFSR, frame-rate envelope
// and length counter, registered 9-bit sample for the mixer.
module channel_4_noise
    import apu_pkg::*;
#(
    parameter int DIV       = 25,
    parameter int GAIN      = 5,
    parameter int OUT_WIDTH = SAMPLE_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_pulse,
    input  logic                 i_trigger,
    input  logic [11:0]          i_period,
    input  logic                 i_mode,
    input  logic [7:0]           i_length,
    input  logic                 i_loop,
    input  logic                 i_const_vol,
    input  logic [3:0]           i_volume,
    output logic [OUT_WIDTH-1:0] o_output,
    output logic                 o_active
);

    localparam int                   PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]     PRE_TC = PRE_W'(DIV - 1);
    localparam logic [OUT_WIDTH-1:0] GAIN_W = OUT_WIDTH'(GAIN);

    logic [PRE_W-1:0]      pre_cnt;
    logic                  tick;
    logic [11:0]           timer;
    logic                  lfsr_step;
    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic [7:0]            length;
    env_t                  env_q;
    env_t                  env_d;
    logic [3:0]            vol;
    logic [OUT_WIDTH-1:0]  sample;

    // Prescaler
    assign tick = (pre_cnt == PRE_TC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Period timer: the reload value is sampled only when it expires.
    assign lfsr_step = tick && (timer == 12'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer <= 12'd0;
        end else if (tick) begin
            if (timer == 12'd0) begin
                timer <= i_period;
            end else begin
                timer <= timer - 12'd1;
            end
        end
    end

    noise_lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_step  (lfsr_step),
        .i_mode  (i_mode),
        .o_state (lfsr_state)
    );

    // Length counter: a trigger overrides a coincident frame decrement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            length <= 8'd0;
        end else if (i_trigger) begin
            length <= i_length;
        end else if (i_frame_pulse && (length != 8'd0) && !i_loop) begin
            length <= length - 8'd1;
        end
    end

    // Envelope
    always_comb begin
        env_d = env_q;
        if (i_frame_pulse) begin
            if (env_q.start) begin
                env_d.start   = 1'b0;
                env_d.decay   = ENV_MAX;
                env_d.divider = i_volume;
            end else if (env_q.divider == 4'd0) begin
                env_d.divider = i_volume;
                if (env_q.decay != 4'd0) begin
                    env_d.decay = env_q.decay - 4'd1;
                end else if (i_loop) begin
                    env_d.decay = ENV_MAX;
                end
            end else begin
                env_d.divider = env_q.divider - 4'd1;
            end
        end
        // A same-cycle trigger re-arms start so the restart lands on the next frame.
        if (i_trigger) begin
            env_d.start = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end

    // Output stage
    assign vol    = i_const_vol ? i_volume : env_q.decay;
    assign sample = {{(OUT_WIDTH-4){1'b0}}, vol} * GAIN_W;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_output <= '0;
            o_active <= 1'b0;
        end else begin
            o_output <= ((length == 8'd0) || lfsr_state[0]) ? '0 : sample;
            o_active <= (length != 8'd0);
        end
    end

endmodule
